// File: rtl/temp_f_converter.sv
// Celsius-to-Fahrenheit converter for the display path: sequential multiply, restoring
// divide by 5, offset/saturate at 299, then double-dabble into 10-bit packed BCD.
module temp_f_converter #(
    parameter int unsigned C_WIDTH = 7
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               TEMP_C_VALID,
    input  logic [C_WIDTH-1:0] TEMP_C,
    output logic               TEMP_C_READY,
    output logic [9:0]         TEMP_F,
    output logic               TEMP_F_UPDATE,
    output logic               TEMP_SAT
);

    localparam int unsigned DivW = C_WIDTH + 4;
    localparam int unsigned SumW = (DivW + 1 > 10) ? DivW + 1 : 10;
    localparam int unsigned CntW = ($clog2(DivW) > 4) ? $clog2(DivW) : 4;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StAdd,
        StBcd,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [C_WIDTH-1:0] c_q, c_d;
    logic [DivW-1:0]    quot_q, quot_d;
    logic [2:0]         rem_q, rem_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [8:0]         bin_q, bin_d;
    logic [9:0]         bcd_q, bcd_d;
    logic               sat_pend_q, sat_pend_d;
    logic [9:0]         temp_f_q, temp_f_d;
    logic               sat_q, sat_d;
    logic               upd_q, upd_d;

    logic [3:0]         trial;
    logic [3:0]         trial_sub;
    logic               qbit;
    logic [SumW-1:0]    sum;
    logic [3:0]         ones_adj;
    logic [3:0]         tens_adj;

    // Dividend shifts out of quot_q's MSB while quotient bits shift in at the LSB.
    assign trial     = {rem_q, quot_q[DivW-1]};
    assign trial_sub = trial - 4'd5;
    assign qbit      = (trial >= 4'd5);
    assign sum       = SumW'(quot_q) + SumW'(32);
    assign ones_adj  = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    assign tens_adj  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        sat_pend_d = sat_pend_q;
        temp_f_d   = temp_f_q;
        sat_d      = sat_q;
        upd_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (TEMP_C_VALID) begin
                    c_d     = TEMP_C;
                    state_d = StMul;
                end
            end
            StMul: begin
                quot_d  = (DivW'(c_q) << 3) + DivW'(c_q) + DivW'(2);
                rem_d   = 3'd0;
                cnt_d   = CntW'(DivW - 1);
                state_d = StDiv;
            end
            StDiv: begin
                quot_d = {quot_q[DivW-2:0], qbit};
                rem_d  = qbit ? trial_sub[2:0] : trial[2:0];
                if (cnt_q == '0) begin
                    state_d = StAdd;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StAdd: begin
                if (sum > SumW'(299)) begin
                    bin_d      = 9'd299;
                    sat_pend_d = 1'b1;
                end else begin
                    bin_d      = sum[8:0];
                    sat_pend_d = 1'b0;
                end
                bcd_d   = 10'd0;
                cnt_d   = CntW'(8);
                state_d = StBcd;
            end
            StBcd: begin
                // Hundreds never exceeds 2, so only tens and ones need the +3 correction.
                bcd_d = {bcd_q[8], tens_adj, ones_adj, bin_q[8]};
                bin_d = {bin_q[7:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                temp_f_d = bcd_q;
                sat_d    = sat_pend_q;
                upd_d    = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            c_q        <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            sat_pend_q <= 1'b0;
            temp_f_q   <= 10'h000;
            sat_q      <= 1'b0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            sat_pend_q <= sat_pend_d;
            temp_f_q   <= temp_f_d;
            sat_q      <= sat_d;
            upd_q      <= upd_d;
        end
    end

    assign TEMP_C_READY  = (state_q == StIdle);
    assign TEMP_F        = temp_f_q;
    assign TEMP_F_UPDATE = upd_q;
    assign TEMP_SAT      = sat_q;

endmodule

// File: tb/tb_temp_f_converter.sv
// Bench for temp_f_converter: default-width and 8-bit instances, a formula-level model
// with a per-cycle monitor, plus directed conversions with literal expectations.
module tb_temp_f_converter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid [2];
    logic [7:0] c_in  [2];
    logic       ready [2];
    logic [9:0] f_o   [2];
    logic       upd   [2];
    logic       sat   [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    temp_f_converter #(.C_WIDTH(7)) u_dut7 (
        .CLOCK_50      (clk),
        .RESET_N       (rst_n),
        .TEMP_C_VALID  (valid[0]),
        .TEMP_C        (c_in[0][6:0]),
        .TEMP_C_READY  (ready[0]),
        .TEMP_F        (f_o[0]),
        .TEMP_F_UPDATE (upd[0]),
        .TEMP_SAT      (sat[0])
    );

    temp_f_converter #(.C_WIDTH(8)) u_dut8 (
        .CLOCK_50      (clk),
        .RESET_N       (rst_n),
        .TEMP_C_VALID  (valid[1]),
        .TEMP_C        (c_in[1]),
        .TEMP_C_READY  (ready[1]),
        .TEMP_F        (f_o[1]),
        .TEMP_F_UPDATE (upd[1]),
        .TEMP_SAT      (sat[1])
    );

    // Returns {sat, packed BCD} straight from the rounding formula and decimal digits.
    function automatic logic [10:0] model(int c);
        int   f;
        logic s;
        f = (9 * c + 2) / 5 + 32;
        s = 1'b0;
        if (f > 299) begin
            f = 299;
            s = 1'b1;
        end
        return {s, 2'(f / 100), 4'((f / 10) % 10), 4'(f % 10)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle monitor
    bit         pend     [2] = '{0, 0};
    int         due      [2] = '{0, 0};
    logic [9:0] exp_f    [2];
    logic       exp_s    [2];
    logic [9:0] held_f   [2] = '{10'h000, 10'h000};
    logic       held_s   [2] = '{1'b0, 1'b0};
    int         last_acc [2] = '{0, 0};
    int         prev_acc [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                pend[i]   = 1'b0;
                held_f[i] = 10'h000;
                held_s[i] = 1'b0;
                chk("rst_temp_f", 32'(f_o[i]), 32'h000);
                chk("rst_sat", 32'(sat[i]), 32'd0);
                chk("rst_update", 32'(upd[i]), 32'd0);
                chk("rst_ready", 32'(ready[i]), 32'd1);
            end else begin
                if (pend[i] && cyc == due[i]) begin
                    chk("mon_update", 32'(upd[i]), 32'd1);
                    chk("mon_temp_f", 32'(f_o[i]), 32'(exp_f[i]));
                    chk("mon_sat", 32'(sat[i]), 32'(exp_s[i]));
                    chk("mon_ready_back", 32'(ready[i]), 32'd1);
                    held_f[i] = exp_f[i];
                    held_s[i] = exp_s[i];
                    pend[i]   = 1'b0;
                end else begin
                    chk("mon_no_update", 32'(upd[i]), 32'd0);
                    chk("mon_hold_f", 32'(f_o[i]), 32'(held_f[i]));
                    chk("mon_hold_sat", 32'(sat[i]), 32'(held_s[i]));
                    chk("mon_ready", 32'(ready[i]), pend[i] ? 32'd0 : 32'd1);
                end
                if (valid[i] && ready[i]) begin
                    logic [10:0] m;
                    m           = model(i == 0 ? int'(c_in[0][6:0]) : int'(c_in[1]));
                    exp_s[i]    = m[10];
                    exp_f[i]    = m[9:0];
                    pend[i]     = 1'b1;
                    due[i]      = cyc + 1 + (i == 0 ? 23 : 24);
                    prev_acc[i] = last_acc[i];
                    last_acc[i] = cyc + 1;
                end
            end
        end
    end

    task automatic convert(int i, int c, logic [9:0] ef, logic es);
        bit ok;
        @(posedge clk);
        #1;
        valid[i] = 1'b1;
        c_in[i]  = 8'(c);
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (ready[i]) ok = 1'b1;
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid[i] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (upd[i]) begin
                ok = 1'b1;
                chk("dir_temp_f", 32'(f_o[i]), 32'(ef));
                chk("dir_sat", 32'(sat[i]), 32'(es));
            end
        end
        if (!ok) chk("update_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [10:0] m;
        rst_n    = 1'b0;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        c_in[0]  = 8'd0;
        c_in[1]  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("pin_c0",   32'(model(0)),   32'h032);
        chk("pin_c2",   32'(model(2)),   32'h036);
        chk("pin_c3",   32'(model(3)),   32'h037);
        chk("pin_c25",  32'(model(25)),  32'h077);
        chk("pin_c38",  32'(model(38)),  32'h100);
        chk("pin_c127", 32'(model(127)), 32'h261);
        chk("pin_c255", 32'(model(255)), 32'h699);

        convert(0, 0,   10'h032, 1'b0);
        convert(0, 25,  10'h077, 1'b0);
        convert(0, 37,  10'h099, 1'b0);
        convert(0, 38,  10'h100, 1'b0);
        convert(0, 127, 10'h261, 1'b0);
        convert(0, 3,   10'h037, 1'b0);
        convert(0, 2,   10'h036, 1'b0);

        for (int c = 0; c < 128; c++) begin
            m = model(c);
            convert(0, c, m[9:0], m[10]);
        end

        // VALID held high with data changing every cycle
        @(posedge clk);
        for (int n = 0; n < 80; n++) begin
            #1;
            valid[0] = 1'b1;
            c_in[0]  = 8'($urandom_range(0, 127));
            @(posedge clk);
        end
        #1;
        valid[0] = 1'b0;
        chk("b2b_spacing", 32'(last_acc[0] - prev_acc[0]), 32'd24);
        repeat (40) @(posedge clk);

        // Abort a conversion with reset
        #1;
        valid[0] = 1'b1;
        c_in[0]  = 8'd100;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_temp_f", 32'(f_o[0]), 32'h000);
        chk("abort_ready", 32'(ready[0]), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        convert(0, 100, 10'h212, 1'b0);

        convert(1, 255, 10'h299, 1'b1);
        convert(1, 20,  10'h068, 1'b0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
